scoreboard_stall: RTL and testbench

- Issue-side hazard controller; the stall counterpart of the execute-stage forwarding path.
- Tracks destination registers whose results cannot yet be forwarded: loads in flight and long-latency multicycle ops (div/rem).
- Holds the decode→execute handoff (issueReady low) until every operand is forwardable or retired, and until any structural conflict on the multicycle unit clears.
- Sits between decode and the decode/execute pipeline register.

---
 rtl/scoreboard_stall.sv | 91 +++++++++
 tb/tb_scoreboard_stall.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_stall.sv
// Issue-side hazard scoreboard: holds decode->execute (issueReady, combinational) on RAW/WAW against
// in-flight loads and long ops, or on a busy long unit; bookkeeping updates one cycle after accept.
module scoreboard_stall #(
   parameter int LONG_LATENCY      = 8,
   parameter int STALL_COUNT_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         issueValid,
   output logic                         issueReady,
   input  logic [4:0]                   issueRs1,
   input  logic [4:0]                   issueRs2,
   input  logic                         issueUsesRs1,
   input  logic                         issueUsesRs2,
   input  logic [4:0]                   issueRd,
   input  logic                         issueWritesRd,
   input  logic [1:0]                   issueClass,
   input  logic                         loadDoneValid,
   input  logic [4:0]                   loadDoneRd,
   input  logic                         killValid,
   input  logic [4:0]                   killRd,
   input  logic                         killIsLong,
   output logic                         longBusy,
   output logic [STALL_COUNT_WIDTH-1:0] stallCount
);

   localparam logic [4:0] LongLatency = 5'(LONG_LATENCY);

   // Bit 0 exists only to keep indexing simple; it is never set.
   logic [31:0] pending, pendingNext;
   logic [4:0]  longRd, longRdNext;
   logic [4:0]  longCnt, longCntNext;
   logic        rawHaz, wawHaz, structHaz;
   logic        accept, isLong, isTracked;

   assign longBusy  = (longCnt != 5'd0);
   assign isLong    = (issueClass == 2'd2);
   assign isTracked = (issueClass == 2'd1) || isLong;

   always_comb begin
      rawHaz     = (issueUsesRs1 && (issueRs1 != 5'd0) && pending[issueRs1]) ||
                   (issueUsesRs2 && (issueRs2 != 5'd0) && pending[issueRs2]);
      wawHaz     = issueWritesRd && (issueRd != 5'd0) && pending[issueRd];
      structHaz  = isLong && longBusy;
      issueReady = !(rawHaz || wawHaz || structHaz);
      accept     = issueValid && issueReady;
   end

   // Clears first, then the accept-side set, so a new producer beats a stale clear.
   always_comb begin
      pendingNext = pending;
      if (longCnt == 5'd1)
         pendingNext[longRd] = 1'b0;
      if (loadDoneValid)
         pendingNext[loadDoneRd] = 1'b0;
      if (killValid)
         pendingNext[killRd] = 1'b0;
      if (accept && issueWritesRd && (issueRd != 5'd0) && isTracked)
         pendingNext[issueRd] = 1'b1;
      pendingNext[0] = 1'b0;
   end

   always_comb begin
      longCntNext = longCnt;
      longRdNext  = longRd;
      if (accept && isLong) begin
         longCntNext = LongLatency;
         longRdNext  = issueRd;
      end else if (killValid && killIsLong) begin
         longCntNext = 5'd0;
      end else if (longCnt != 5'd0) begin
         longCntNext = longCnt - 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= '0;
         longRd     <= '0;
         longCnt    <= '0;
         stallCount <= '0;
      end else begin
         pending <= pendingNext;
         longRd  <= longRdNext;
         longCnt <= longCntNext;
         if (issueValid && !issueReady && (stallCount != '1))
            stallCount <= stallCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_scoreboard_stall.sv
// Directed bench for scoreboard_stall: per-cycle vector table plus hand sequences
// for structural stall, long-op kill probing and asynchronous reset mid-operation.
module tb_scoreboard_stall;

   localparam int LL = 8;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          issueValid, issueReady;
   logic [4:0]    issueRs1, issueRs2, issueRd;
   logic          issueUsesRs1, issueUsesRs2, issueWritesRd;
   logic [1:0]    issueClass;
   logic          loadDoneValid;
   logic [4:0]    loadDoneRd;
   logic          killValid;
   logic [4:0]    killRd;
   logic          killIsLong;
   logic          longBusy;
   logic [SW-1:0] stallCount;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   scoreboard_stall #(.LONG_LATENCY(LL), .STALL_COUNT_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n),
      .issueValid(issueValid), .issueReady(issueReady),
      .issueRs1(issueRs1), .issueRs2(issueRs2),
      .issueUsesRs1(issueUsesRs1), .issueUsesRs2(issueUsesRs2),
      .issueRd(issueRd), .issueWritesRd(issueWritesRd), .issueClass(issueClass),
      .loadDoneValid(loadDoneValid), .loadDoneRd(loadDoneRd),
      .killValid(killValid), .killRd(killRd), .killIsLong(killIsLong),
      .longBusy(longBusy), .stallCount(stallCount)
   );

   typedef struct {
      logic       v, u1, u2, wr, ld, k, kl;
      logic [4:0] rs1, rs2, rd, ldRd, kRd;
      logic [1:0] cls;
      logic       eReady, eBusy;
      int         eCnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic u1, logic [4:0] rs1, logic u2, logic [4:0] rs2,
                               logic wr, logic [4:0] rd, logic [1:0] cls,
                               logic ld, logic [4:0] ldRd, logic k, logic [4:0] kRd, logic kl,
                               logic eReady, logic eBusy, int eCnt);
      vec_t t;
      t.v = v; t.u1 = u1; t.rs1 = rs1; t.u2 = u2; t.rs2 = rs2; t.wr = wr; t.rd = rd;
      t.cls = cls; t.ld = ld; t.ldRd = ldRd; t.k = k; t.kRd = kRd; t.kl = kl;
      t.eReady = eReady; t.eBusy = eBusy; t.eCnt = eCnt;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      issueValid = t.v; issueUsesRs1 = t.u1; issueRs1 = t.rs1;
      issueUsesRs2 = t.u2; issueRs2 = t.rs2; issueWritesRd = t.wr; issueRd = t.rd;
      issueClass = t.cls; loadDoneValid = t.ld; loadDoneRd = t.ldRd;
      killValid = t.k; killRd = t.kRd; killIsLong = t.kl;
   endtask

   task automatic idle();
      drive(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0, 1,0,0));
   endtask

   task automatic doReset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int stalls;
      // Load-use with a non-valid stalled cycle that must not count
      vecs.push_back(mk(1,1,1,0,0,1,5,1,  0,0,0,0,0, 1,0,0));
      vecs.push_back(mk(0,1,5,0,0,1,10,0, 0,0,0,0,0, 0,0,0));
      vecs.push_back(mk(1,1,5,0,0,1,10,0, 0,0,0,0,0, 0,0,0));
      vecs.push_back(mk(1,1,5,0,0,1,10,0, 0,0,0,0,0, 0,0,1));
      vecs.push_back(mk(1,1,5,0,0,1,10,0, 1,5,0,0,0, 0,0,2));
      vecs.push_back(mk(1,1,5,0,0,1,10,0, 0,0,0,0,0, 1,0,3));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0, 1,0,3));
      // Long op: busy for LL cycles, dependent ready the cycle after
      vecs.push_back(mk(1,1,1,0,0,1,7,2,  0,0,0,0,0, 1,0,3));
      for (int i = 0; i < LL; i++)
         vecs.push_back(mk(1,1,7,0,0,1,11,0, 0,0,0,0,0, 0,1,3+i));
      vecs.push_back(mk(1,1,7,0,0,1,11,0, 0,0,0,0,0, 1,0,11));
      // Kill of a pending load, then kill of the outstanding long op
      vecs.push_back(mk(1,1,1,0,0,1,3,1,  0,0,0,0,0, 1,0,11));
      vecs.push_back(mk(1,1,3,0,0,1,12,0, 0,0,1,3,0, 0,0,11));
      vecs.push_back(mk(1,1,3,0,0,1,12,0, 0,0,0,0,0, 1,0,12));
      vecs.push_back(mk(1,1,1,0,0,1,4,2,  0,0,0,0,0, 1,0,12));
      vecs.push_back(mk(1,0,0,1,4,1,13,0, 0,0,0,0,0, 0,1,12));
      vecs.push_back(mk(1,0,0,1,4,1,13,0, 0,0,1,4,1, 0,1,13));
      vecs.push_back(mk(1,0,0,1,4,1,13,0, 0,0,0,0,0, 1,0,14));
      // x0 is never tracked
      vecs.push_back(mk(1,1,1,0,0,1,0,1,  0,0,0,0,0, 1,0,14));
      vecs.push_back(mk(1,1,0,1,0,1,14,0, 0,0,0,0,0, 1,0,14));
      // WAW on a pending load; the stall counter saturates at 15 here
      vecs.push_back(mk(1,1,1,0,0,1,6,1,  0,0,0,0,0, 1,0,14));
      vecs.push_back(mk(1,1,1,0,0,1,6,0,  0,0,0,0,0, 0,0,14));
      vecs.push_back(mk(1,1,1,0,0,1,6,0,  0,0,0,0,0, 0,0,15));
      vecs.push_back(mk(1,1,1,0,0,1,6,0,  1,6,0,0,0, 0,0,15));
      vecs.push_back(mk(1,1,1,0,0,1,6,0,  0,0,0,0,0, 1,0,15));
      vecs.push_back(mk(0,0,0,0,0,0,0,0,  0,0,0,0,0, 1,0,15));

      doReset();
      chk("reset issueReady", int'(issueReady), 1);
      chk("reset longBusy", int'(longBusy), 0);
      chk("reset stallCount", int'(stallCount), 0);

      foreach (vecs[i]) begin
         drive(vecs[i]);
         @(negedge clk);
         chk($sformatf("vec%0d issueReady", i), int'(issueReady), int'(vecs[i].eReady));
         chk($sformatf("vec%0d longBusy", i), int'(longBusy), int'(vecs[i].eBusy));
         chk($sformatf("vec%0d stallCount", i), int'(stallCount), vecs[i].eCnt);
         nextCycle();
      end

      // Structural: second div two cycles after the first waits for the unit
      doReset();
      drive(mk(1,1,1,0,0,1,7,2, 0,0,0,0,0, 1,0,0));
      chk("struct first div ready", int'(issueReady), 1);
      nextCycle();
      idle();
      nextCycle();
      drive(mk(1,1,1,0,0,1,9,2, 0,0,0,0,0, 1,0,0));
      stalls = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (issueReady) break;
         stalls++;
         nextCycle();
      end
      chk("struct stall cycles", stalls, 7);
      chk("struct ready before accept", int'(issueReady), 1);
      nextCycle();
      idle();
      #1;
      chk("struct stallCount", int'(stallCount), 7);
      chk("struct longBusy after second div", int'(longBusy), 1);
      drive(mk(0,1,9,0,0,1,15,0, 0,0,0,0,0, 1,0,0));
      #1 chk("struct x9 pending", int'(issueReady), 0);
      drive(mk(0,0,9,0,0,1,15,0, 0,0,0,0,0, 1,0,0));
      #1 chk("struct unused rs1 ignored", int'(issueReady), 1);
      drive(mk(0,1,7,0,0,1,15,0, 0,0,0,0,0, 1,0,0));
      #1 chk("struct x7 cleared", int'(issueReady), 1);
      drive(mk(0,1,1,0,0,1,16,2, 0,0,0,0,0, 1,0,0));
      #1 chk("struct div blocked while busy", int'(issueReady), 0);

      // Asynchronous reset with x5 pending and the long counter at 4
      doReset();
      drive(mk(1,1,1,0,0,1,5,1, 0,0,0,0,0, 1,0,0));
      nextCycle();
      drive(mk(1,1,1,0,0,1,8,2, 0,0,0,0,0, 1,0,0));
      nextCycle();
      drive(mk(1,1,5,0,0,1,17,0, 0,0,0,0,0, 1,0,0));
      repeat (4) nextCycle();
      chk("pre-reset stallCount", int'(stallCount), 4);
      chk("pre-reset longBusy", int'(longBusy), 1);
      chk("pre-reset issueReady", int'(issueReady), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset longBusy", int'(longBusy), 0);
      chk("async reset stallCount", int'(stallCount), 0);
      chk("async reset x5 reader ready", int'(issueReady), 1);
      drive(mk(1,1,1,0,0,1,8,2, 0,0,0,0,0, 1,0,0));
      #1 chk("async reset div ready", int'(issueReady), 1);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      nextCycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
